// File: rtl/ahb2_arbiter.sv
// AHB2 bus arbiter: one-hot grant, address/data-phase owner pipeline, burst-aware handover.
// Define AHB2_ARB_LOCK_EN to add hlock/hmastlock locked-transfer support.
module ahb2_arbiter #(
    parameter  int N_MST       = 4,
    parameter  int ARB_MODE    = 1,
    parameter  int DEFAULT_MST = 0,
    localparam int MST_W       = $clog2(N_MST)
) (
    input  logic             hclk,
    input  logic             hreset_n,
    input  logic [N_MST-1:0] hbusreq,
    input  logic [1:0]       htrans,
    input  logic [2:0]       hburst,
    input  logic             hready,
`ifdef AHB2_ARB_LOCK_EN
    input  logic [N_MST-1:0] hlock,
    output logic             hmastlock,
`endif
    output logic [N_MST-1:0] hgrant,
    output logic [MST_W-1:0] hmaster,
    output logic [MST_W-1:0] hmaster_d
);

    localparam logic [1:0]       HT_NONSEQ = 2'b10;
    localparam logic [1:0]       HT_SEQ    = 2'b11;
    localparam logic [MST_W-1:0] DEF_IDX   = MST_W'(DEFAULT_MST);
    // Fixed priority is a round-robin scan that always starts just above the top index.
    localparam logic [MST_W-1:0] FP_BASE   = MST_W'(N_MST - 1);

    function automatic logic [N_MST-1:0] onehot(input logic [MST_W-1:0] idx);
        logic [N_MST-1:0] v;
        v      = {N_MST{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [4:0] burst_load(input logic [2:0] burst);
        logic [4:0] v;
        case (burst)
            3'd2, 3'd3: v = 5'd3;
            3'd4, 3'd5: v = 5'd7;
            3'd6, 3'd7: v = 5'd15;
            default:    v = 5'd0;
        endcase
        return v;
    endfunction

    logic [N_MST-1:0] r_grant;
    logic [MST_W-1:0] r_gidx;
    logic [MST_W-1:0] r_hmaster;
    logic [MST_W-1:0] r_hmaster_d;
    logic [MST_W-1:0] r_ptr;
    logic [4:0]       r_cnt;

    logic [4:0]       w_cnt_nxt;
    logic             w_lock;
    logic             w_permit;
    logic [MST_W-1:0] w_base;
    logic [MST_W:0]   w_sum;
    logic [MST_W-1:0] w_cand;
    logic [MST_W-1:0] w_win;
    logic [MST_W-1:0] w_gidx_nxt;

`ifdef AHB2_ARB_LOCK_EN
    logic r_mastlock;
    assign w_lock    = hlock[r_gidx];
    assign hmastlock = r_mastlock;
`else
    assign w_lock    = 1'b0;
`endif

    // Beats remaining after the transfer presented this cycle is accepted.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case (htrans)
            HT_NONSEQ: w_cnt_nxt = burst_load(hburst);
            HT_SEQ:    w_cnt_nxt = (r_cnt == 5'd0) ? 5'd0 : r_cnt - 5'd1;
            default:   w_cnt_nxt = r_cnt;
        endcase
    end

    // Scan downward so the candidate closest above the base wins.
    always_comb begin
        w_base = (ARB_MODE == 0) ? FP_BASE : r_ptr;
        w_win  = DEF_IDX;
        w_sum  = {(MST_W+1){1'b0}};
        w_cand = {MST_W{1'b0}};
        for (int k = N_MST; k >= 1; k--) begin
            w_sum  = {1'b0, w_base} + (MST_W+1)'(k);
            w_sum  = (w_sum >= (MST_W+1)'(N_MST)) ? (w_sum - (MST_W+1)'(N_MST)) : w_sum;
            w_cand = w_sum[MST_W-1:0];
            w_win  = hbusreq[w_cand] ? w_cand : w_win;
        end
    end

    // Handover only once the burst is on its final beat and the bus is not locked.
    always_comb begin
        w_permit = (w_cnt_nxt <= 5'd1) && !w_lock;
        if (w_permit) begin
            w_gidx_nxt = (|hbusreq) ? w_win : DEF_IDX;
        end else begin
            w_gidx_nxt = r_gidx;
        end
    end

    // Grant, ownership pipeline, burst counter and round-robin pointer.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_grant     <= onehot(DEF_IDX);
            r_gidx      <= DEF_IDX;
            r_hmaster   <= DEF_IDX;
            r_hmaster_d <= DEF_IDX;
            r_ptr       <= DEF_IDX;
            r_cnt       <= 5'd0;
        end else if (hready) begin
            r_grant     <= onehot(w_gidx_nxt);
            r_gidx      <= w_gidx_nxt;
            r_hmaster   <= r_gidx;
            r_hmaster_d <= r_hmaster;
            r_cnt       <= w_cnt_nxt;
            if (w_permit && (|hbusreq)) begin
                r_ptr <= w_win;
            end
        end
    end

`ifdef AHB2_ARB_LOCK_EN
    // Lock indication travels with the address-phase owner.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_mastlock <= 1'b0;
        end else if (hready) begin
            r_mastlock <= hlock[r_gidx];
        end
    end
`endif

    assign hgrant    = r_grant;
    assign hmaster   = r_hmaster;
    assign hmaster_d = r_hmaster_d;

endmodule

// File: doc/ahb2_arbiter.md
Name: ahb2_arbiter

Overview:
- Parametrised AHB2 bus arbiter for N masters, each connected through an AHB2 master interface (hbusreq/hgrant).
- Selects one owner per address phase and drives one-hot hgrant.
- Tracks address-phase and data-phase ownership (hmaster, hmaster_d) for the shared bus mux.
- Holds ownership across fixed-length bursts; arbitration policy (fixed priority or round-robin) is set by parameter.

Parameters:
- N_MST, 4, number of masters (2..16); MST_W = $clog2(N_MST) is a localparam.
- ARB_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round-robin.
- DEFAULT_MST, 0, master granted when no hbusreq is asserted.

Ports:
- hclk  input  1  bus clock
- hreset_n  input  1  asynchronous active-low reset
- hbusreq  input  N_MST  per-master bus request
- htrans  input  2  bus htrans from current address-phase master
- hburst  input  3  bus hburst from current address-phase master
- hready  input  1  bus hready (transfer accepted when 1 at rising edge)
- hgrant  output  N_MST  one-hot grant
- hmaster  output  MST_W  address-phase owner index
- hmaster_d  output  MST_W  data-phase owner index (hwdata/response mux select)

Behaviour:
- Reset values:
  - hgrant = one-hot DEFAULT_MST; hmaster = hmaster_d = DEFAULT_MST.
  - Burst counter = 0; round-robin pointer = DEFAULT_MST.
- All state is updated only on a rising hclk edge where hready = 1. With hready = 0, every output and all state hold.
- Ownership pipeline at each hready edge:
  - hmaster <= index(hgrant).
  - hmaster_d <= hmaster (previous value).
  - A newly granted master therefore drives address one hready-cycle after hgrant rises.
- Burst counter cnt (5 bits) counts beats remaining after the accepted transfer:
  - Accepted NONSEQ with hburst INCR4/WRAP4 loads cnt = 3; INCR8/WRAP8 loads 7; INCR16/WRAP16 loads 15.
  - Accepted NONSEQ with SINGLE or INCR loads cnt = 0.
  - Accepted SEQ decrements cnt, saturating at 0.
  - IDLE and BUSY leave cnt unchanged.
- Arbitration permit at a hready edge: next cnt <= 1.
  - The grant therefore moves when the second-to-last beat is accepted, and the new owner's first address follows the last beat with no gap.
  - IDLE or BUSY with cnt >= 2 does not permit arbitration.
  - While not permitted, hgrant holds even if the owner drops hbusreq.
- Winner selection (only when permitted):
  - ARB_MODE 0: lowest-index asserted hbusreq.
  - ARB_MODE 1: first asserted hbusreq scanning upward from pointer+1 with wrap-around at N_MST-1 -> 0. The pointer updates to the winner whenever a winner is selected.
  - No request asserted: grant DEFAULT_MST; the round-robin pointer is unchanged.
  - If the current owner is the only requester, it keeps the grant.
- hgrant is always exactly one-hot; it is never all-zero, including after reset.
- hresp is not observed; SPLIT/RETRY handling is out of scope.
- Reset asserted mid-burst: all state returns immediately (asynchronously) to reset values.

Optional Feature:
- Macro: AHB2_ARB_LOCK_EN.
- When defined:
  - Adds input hlock [N_MST] and output hmastlock [1].
  - Arbitration is not permitted while hlock[index(hgrant)] = 1, regardless of cnt.
  - hmastlock <= hlock[index(hgrant)] at each hready edge, aligned with hmaster; reset value 0.
- When undefined: neither port exists and lock has no effect on arbitration.

Test Plan:
- Reset, no requests -> hgrant = 4'b0001, hmaster = 0, hmaster_d = 0, all held with hreadys.
- ARB_MODE 1, hbusreq = 4'b1111, only IDLE transfers, hready = 1 -> grant sequence 1,2,3,0,1; hmaster lags hgrant by one cycle; hmaster_d lags by two.
- Master 1 issues INCR4 (NONSEQ + 3 SEQ), master 2 requesting throughout -> hgrant moves to 2 at the edge accepting beat 3; hmaster = 2 in the cycle after beat 4 address.
- Same INCR4 with hready = 0 for 3 cycles during beat 2 -> hgrant, hmaster and cnt frozen; handover still occurs after beat 3 is accepted.
- ARB_MODE 0, hbusreq = 4'b1010 -> master 1 wins every permitted edge; master 3 is never granted until hbusreq[1] drops.
- AHB2_ARB_LOCK_EN, master 2 holds hlock with SINGLE transfers, master 0 requesting -> grant stays on 2 and hmastlock = 1; grant moves to 0 one edge after hlock falls.
